// File: rtl/nf10_wrr_grant_scheduler.sv
// Packet-granular weighted round-robin grant scheduler with per-port saturating packet counters.
// Latency: grant one cycle after an eligible request is sampled in ARB; exactly one idle ARB cycle between packets.
// Backpressure: grant held through stalled/non-last beats; releases only on an accepted tlast beat.
module nf10_wrr_grant_scheduler #(
  parameter int C_NUM_PORTS    = 5,
  parameter int C_WEIGHT_WIDTH = 4,
  parameter int C_CNT_WIDTH    = 32
) (
  input  logic                                    axi_aclk,
  input  logic                                    axi_reset,
  input  logic [C_NUM_PORTS-1:0]                  req,
  input  logic [C_NUM_PORTS*C_WEIGHT_WIDTH-1:0]   weight_flat,
  input  logic                                    out_tvalid,
  input  logic                                    out_tready,
  input  logic                                    out_tlast,
  output logic [C_NUM_PORTS-1:0]                  grant,
  output logic                                    grant_valid,
  input  logic [2:0]                              stat_sel,
  input  logic                                    stat_clear,
  output logic [C_CNT_WIDTH-1:0]                  stat_count
);

  localparam int N     = C_NUM_PORTS;
  localparam int W     = C_WEIGHT_WIDTH;
  localparam int CUR_W = $clog2(C_NUM_PORTS);

  typedef enum logic {ST_ARB = 1'b0, ST_PKT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CUR_W-1:0] cur, cur_nxt;
  logic [W-1:0]     credit, credit_nxt;
  // held=0 after reset: no port owns a run yet, so the first pick comes from the scan (port 0).
  logic             held, held_nxt;
  logic             pkt_done;
  logic             eop;

  logic [W-1:0]     weight [N];
  logic [N-1:0]     eligible;

  logic             scan_found;
  logic [CUR_W-1:0] scan_pick;
  logic [CUR_W-1:0] scan_idx;

  logic [C_CNT_WIDTH-1:0] counter [N];
  logic [C_CNT_WIDTH-1:0] sel_val;

  assign eop = out_tvalid & out_tready & out_tlast;

  // Unpack weights and derive per-port eligibility (requesting and not disabled).
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N; i++) begin
      weight[i]   = weight_flat[i*W +: W];
      eligible[i] = req[i] & (weight_flat[i*W +: W] != '0);
    end
  end

  // Round-robin scan: first eligible port after cur, wrapping so cur itself is checked last.
  always_comb begin
    scan_found = 1'b0;
    scan_pick  = cur;
    scan_idx   = cur;
    for (int k = 1; k <= N; k++) begin
      scan_idx = CUR_W'((int'(cur) + k) % N);
      if (!scan_found && eligible[scan_idx]) begin
        scan_found = 1'b1;
        scan_pick  = scan_idx;
      end
    end
  end

  // Next-state and grant outputs: keep the current port while credit remains, else rotate.
  always_comb begin
    state_nxt   = state;
    cur_nxt     = cur;
    credit_nxt  = credit;
    held_nxt    = held;
    pkt_done    = 1'b0;
    grant       = '0;
    grant_valid = 1'b0;
    unique case (state)
      ST_ARB: begin
        if (held && eligible[cur] && (credit < weight[cur])) begin
          state_nxt = ST_PKT;
        end else if (scan_found) begin
          cur_nxt    = scan_pick;
          credit_nxt = '0;
          held_nxt   = 1'b1;
          state_nxt  = ST_PKT;
        end
      end
      ST_PKT: begin
        grant[cur]  = 1'b1;
        grant_valid = 1'b1;
        if (eop) begin
          pkt_done  = 1'b1;
          state_nxt = ST_ARB;
          if (credit != '1) begin
            credit_nxt = credit + W'(1);
          end
        end
      end
      default: state_nxt = ST_ARB;
    endcase
  end

  // FSM state register; reset points cur at the last port so the scan starts at port 0.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state  <= ST_ARB;
      cur    <= CUR_W'(N - 1);
      credit <= '0;
      held   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cur    <= cur_nxt;
      credit <= credit_nxt;
      held   <= held_nxt;
    end
  end

  // Per-port saturating packet counters; clear wins over a same-cycle increment.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      for (int i = 0; i < N; i++) begin
        counter[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (stat_clear) begin
          counter[i] <= '0;
        end else if (pkt_done && (cur == CUR_W'(i)) && (counter[i] != '1)) begin
          counter[i] <= counter[i] + C_CNT_WIDTH'(1);
        end
      end
    end
  end

  // Readback mux; out-of-range selects read zero.
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < N; i++) begin
      if (stat_sel == 3'(i)) begin
        sel_val = counter[i];
      end
    end
  end

  // Registered readback so stat_count lags stat_sel by one cycle.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      stat_count <= '0;
    end else begin
      stat_count <= sel_val;
    end
  end

endmodule

// File: tb/tb_nf10_wrr_grant_scheduler.sv
// Bench for the WRR grant scheduler: reference model plus directed scenarios.
// A second instance with 4-bit counters shares all stimulus to exercise counter saturation.
// Inputs are driven 1ns after the rising edge; outputs are compared on the falling edge.
module tb_nf10_wrr_grant_scheduler;

  localparam int N = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  req = '0;
  logic [19:0] weight_flat = '0;
  logic        out_tvalid = 1'b0;
  logic        out_tready = 1'b0;
  logic        out_tlast = 1'b0;
  logic [2:0]  stat_sel = '0;
  logic        stat_clear = 1'b0;

  logic [4:0]  grant, grant4;
  logic        grant_valid, grant_valid4;
  logic [31:0] stat_count;
  logic [3:0]  stat_count4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nf10_wrr_grant_scheduler #(.C_NUM_PORTS(5), .C_WEIGHT_WIDTH(4), .C_CNT_WIDTH(32)) dut (
    .axi_aclk(clk), .axi_reset(rst), .req(req), .weight_flat(weight_flat),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .grant(grant), .grant_valid(grant_valid),
    .stat_sel(stat_sel), .stat_clear(stat_clear), .stat_count(stat_count)
  );

  nf10_wrr_grant_scheduler #(.C_NUM_PORTS(5), .C_WEIGHT_WIDTH(4), .C_CNT_WIDTH(4)) dut4 (
    .axi_aclk(clk), .axi_reset(rst), .req(req), .weight_flat(weight_flat),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .grant(grant4), .grant_valid(grant_valid4),
    .stat_sel(stat_sel), .stat_clear(stat_clear), .stat_count(stat_count4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_owner: port currently holding a packet grant (-1 = arbitrating)
  // m_last:  port that owns the current run; m_run: packets it sent in this run
  int m_owner = -1;
  int m_last  = N - 1;
  int m_run   = 1 << 30;
  int m_stat  = 0;
  int m_cnt [N] = '{default: 0};

  function automatic int wt(input int i);
    return int'(weight_flat[i*4 +: 4]);
  endfunction

  always @(posedge clk or posedge rst) begin
    int p;
    if (rst) begin
      m_owner = -1;
      m_last  = N - 1;
      m_run   = 1 << 30;
      m_stat  = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      m_stat = (int'(stat_sel) < N) ? m_cnt[stat_sel] : 0;
      if (m_owner < 0) begin
        if (req[m_last] && m_run < wt(m_last)) begin
          m_owner = m_last;
        end else begin
          for (int k = 1; k <= N; k++) begin
            p = (m_last + k) % N;
            if (m_owner < 0 && req[p] && wt(p) > 0) begin
              m_owner = p;
              m_last  = p;
              m_run   = 0;
            end
          end
        end
      end else if (out_tvalid && out_tready && out_tlast) begin
        m_cnt[m_owner] = m_cnt[m_owner] + 1;
        m_run   = m_run + 1;
        m_owner = -1;
      end
      if (stat_clear) begin
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [4:0] exp_g;
    exp_g = (m_owner >= 0) ? (5'b00001 << m_owner) : 5'b00000;
    check("model_grant", grant, exp_g);
    check("model_grant_valid", grant_valid, m_owner >= 0);
    check("model_grant_w4", grant4, exp_g);
    check("model_stat_count", stat_count, m_stat);
    check("model_stat_count_w4", stat_count4, (m_stat > 15) ? 15 : m_stat);
  end

  // ---------------- stimulus helpers ----------------
  function automatic int oh_idx(input logic [4:0] g);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (g == (5'b00001 << i)) r = i;
    return r;
  endfunction

  task automatic apply_reset(input logic [19:0] w, input logic [4:0] r);
    rst = 1'b1;
    req = '0;
    out_tvalid = 1'b0; out_tready = 1'b0; out_tlast = 1'b0;
    stat_clear = 1'b0;
    @(posedge clk); #1;
    weight_flat = w;
    req = r;
    rst = 1'b0;
  endtask

  task automatic wait_grant(output int port, output int waited);
    waited = 0;
    while (!grant_valid && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    check("grant_wait", grant_valid, 1'b1);
    port = oh_idx(grant);
  endtask

  task automatic send(input int beats, input bit clr_last);
    for (int b = 0; b < beats; b++) begin
      out_tvalid = 1'b1;
      out_tready = 1'b1;
      out_tlast  = (b == beats - 1);
      stat_clear = clr_last && (b == beats - 1);
      @(posedge clk); #1;
    end
    out_tvalid = 1'b0; out_tready = 1'b0; out_tlast = 1'b0; stat_clear = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int p, wc, bad;
    int t1_exp [6] = '{0, 1, 2, 3, 4, 0};
    int t2_exp [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

    @(posedge clk); #1;
    check("reset_grant", grant, 0);
    check("reset_grant_valid", grant_valid, 0);
    check("reset_stat_count", stat_count, 0);

    // T1: equal weights, all requesting, 2-beat packets
    apply_reset(20'h11111, 5'b11111);
    for (int i = 0; i < 6; i++) begin
      wait_grant(p, wc);
      check("t1_port", p, t1_exp[i]);
      check("t1_bubble", wc, 1);
      send(2, 1'b0);
    end

    // T2: w0=3, w1=1
    apply_reset(20'h11113, 5'b00011);
    for (int i = 0; i < 8; i++) begin
      wait_grant(p, wc);
      check("t2_port", p, t2_exp[i]);
      send(1, 1'b0);
    end
    stat_sel = 3'd0; @(posedge clk); #1;
    check("t2_cnt0", stat_count, 6);
    stat_sel = 3'd1; @(posedge clk); #1;
    check("t2_cnt1", stat_count, 2);
    stat_sel = 3'd7; @(posedge clk); #1;
    check("t2_sel_out_of_range", stat_count, 0);

    // T3: weight 0 disables a requesting port
    apply_reset(20'h11011, 5'b00100);
    bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (grant_valid) bad++;
    end
    check("t3_valid_cycles", bad, 0);
    stat_sel = 3'd2; @(posedge clk); #1;
    check("t3_cnt2", stat_count, 0);

    // T4: stalled packet on port 3 with request dropped
    apply_reset(20'h11111, 5'b01000);
    wait_grant(p, wc);
    check("t4_port", p, 3);
    out_tvalid = 1'b1; out_tready = 1'b1; out_tlast = 1'b0;
    @(posedge clk); #1;
    req = 5'b00000; out_tready = 1'b0; out_tlast = 1'b1;
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (grant !== 5'b01000) bad++;
    end
    check("t4_grant_held", bad, 0);
    out_tready = 1'b1;
    @(posedge clk); #1;
    out_tvalid = 1'b0; out_tready = 1'b0; out_tlast = 1'b0;
    check("t4_grant_after_eop", grant, 0);
    stat_sel = 3'd3; @(posedge clk); #1;
    check("t4_cnt3", stat_count, 1);

    // T5a: clear in the EOP cycle of port 1
    apply_reset(20'h11111, 5'b00010);
    wait_grant(p, wc);
    send(1, 1'b0);
    stat_sel = 3'd1; @(posedge clk); #1;
    check("t5_cnt1_before_clear", stat_count, 1);
    wait_grant(p, wc);
    send(1, 1'b1);
    req = 5'b00000;
    @(posedge clk); #1;
    check("t5_cnt1_after_clear", stat_count, 0);

    // T5b: 20 packets on port 0; 4-bit instance saturates
    apply_reset(20'h11111, 5'b00001);
    for (int i = 0; i < 20; i++) begin
      wait_grant(p, wc);
      send(1, 1'b0);
    end
    stat_sel = 3'd0; @(posedge clk); #1;
    check("t5_cnt0_w32", stat_count, 20);
    check("t5_cnt0_w4_saturated", stat_count4, 15);

    // T6: reset in the second beat of a port-2 packet
    apply_reset(20'h11111, 5'b00100);
    wait_grant(p, wc);
    check("t6_port", p, 2);
    out_tvalid = 1'b1; out_tready = 1'b1; out_tlast = 1'b0;
    @(posedge clk); #1;
    out_tlast = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("t6_grant_in_reset", grant, 0);
    check("t6_valid_in_reset", grant_valid, 0);
    out_tvalid = 1'b0; out_tready = 1'b0; out_tlast = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    req = 5'b00100;
    wait_grant(p, wc);
    check("t6_first_grant", grant, 5'b00100);
    check("t6_arb_cycles", wc, 1);

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
